// File: rtl/pdm_stim_tx.sv
// First-order sigma-delta (PDM) stimulus transmitter: one-deep sample buffer,
// OSR clocks per sample, complementary PDM pins and underrun accounting.
module pdm_stim_tx #(
  parameter int WIDTH = 8,
  parameter int OSR   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pdm_p,
  output logic             pdm_n,
  output logic             frame_strobe,
  output logic             underrun,
  output logic [7:0]       underrun_cnt,
  output logic             busy
);

  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] acc;
  logic [PW-1:0]    phase;
  logic [WIDTH:0]   sum;
  logic             frame_end;
  logic             accept;
  logic             load;

  assign sum       = {1'b0, acc} + {1'b0, act};
  assign frame_end = (state == RUN) && (phase == PHASE_LAST);
  assign accept    = ena && sample_valid && !buf_full;
  assign load      = ena && buf_full && ((state == IDLE) || frame_end);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: default assignment first, so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (buf_full) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode; ready comes straight from the buffer flop.
  always_comb begin
    sample_ready = !buf_full;
    busy         = (state == RUN);
  end

  // Buffer, modulator datapath and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data     <= '0;
      buf_full     <= 1'b0;
      act          <= '0;
      acc          <= '0;
      phase        <= '0;
      pdm_p        <= 1'b0;
      pdm_n        <= 1'b0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
      if (!ena) begin
        // Disable flushes the buffer and restarts the modulator from zero.
        buf_full <= 1'b0;
        acc      <= '0;
        phase    <= '0;
        pdm_p    <= 1'b0;
        pdm_n    <= 1'b0;
      end else begin
        if (load) begin
          act          <= buf_data;
          buf_full     <= 1'b0;
          frame_strobe <= 1'b1;
        end
        if (accept) begin
          buf_data <= sample_in;
          buf_full <= 1'b1;
        end
        if (state == IDLE) begin
          acc   <= '0;
          phase <= '0;
          pdm_p <= 1'b0;
          pdm_n <= 1'b0;
        end else begin
          // Accumulator runs across frames so quantisation error carries over.
          acc   <= sum[WIDTH-1:0];
          pdm_p <= sum[WIDTH];
          pdm_n <= !sum[WIDTH];
          phase <= frame_end ? '0 : phase + PW'(1);
          if (frame_end && !buf_full) begin
            underrun <= 1'b1;
            if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule
